// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: responder end of the processor data-memory port.
// Word RAM at the bottom of the 12-bit word space plus an MMIO window at
// 0xF00 (cycle counter, LED register, TX FIFO data/status). One cycle of
// read latency, read-before-write on a same-address write.
// Optional feature macro: DMEM_RESP_TXFIFO_EN builds the byte TX FIFO;
// without it the FIFO registers read 0 and the drain port is tied idle.
module dmem_mmio_responder #(
  parameter int RAM_DEPTH = 1024,
  parameter int TX_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          RAM_AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [12:0] RAM_TOP     = 13'(RAM_DEPTH);
  localparam logic [11:0] ADDR_CYCLE  = 12'hF00;
  localparam logic [11:0] ADDR_LED    = 12'hF01;
  localparam logic [11:0] ADDR_TXSTAT = 12'hF03;

  if (RAM_DEPTH < 1 || RAM_DEPTH > 3840) begin : g_bad_ram_depth
    $error("dmem_mmio_responder: RAM_DEPTH must be 1..3840");
  end
  if (TX_DEPTH < 2 || TX_DEPTH > 16 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
    $error("dmem_mmio_responder: TX_DEPTH must be a power of 2 in 2..16");
  end

  logic [31:0]       ram [RAM_DEPTH];
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       cycle_cnt;
  logic [31:0]       mmio_rd;
  logic [31:0]       tx_status;
  logic [31:0]       ram_q_p1;
  logic [31:0]       mmio_q_p1;
  logic              sel_ram_p1;

  assign ram_hit = {1'b0, address_dmem} < RAM_TOP;
  assign ram_idx = address_dmem[RAM_AW-1:0];

  // MMIO read mux; holes and write-only registers read as zero
  always_comb begin
    mmio_rd = 32'd0;
    case (address_dmem)
      ADDR_CYCLE:  mmio_rd = cycle_cnt;
      ADDR_LED:    mmio_rd = {24'd0, leds};
      ADDR_TXSTAT: mmio_rd = tx_status;
      default:     mmio_rd = 32'd0;
    endcase
  end

  // ---- stage p1: RAM word and MMIO value captured on the same edge ----
  // RAM write and synchronous read; the read sees the pre-write word
  always_ff @(posedge clock) begin
    if (wren && ram_hit) begin
      ram[ram_idx] <= data;
    end
    ram_q_p1 <= ram[ram_idx];
  end

  // Read-source select and MMIO snapshot; reset forces q_dmem to zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_ram_p1 <= 1'b0;
      mmio_q_p1  <= 32'd0;
    end else begin
      sel_ram_p1 <= ram_hit;
      mmio_q_p1  <= mmio_rd;
    end
  end

  assign q_dmem = sel_ram_p1 ? ram_q_p1 : mmio_q_p1;

  // Free-running cycle counter and LED register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'd0;
      leds      <= 8'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wren && (address_dmem == ADDR_LED)) begin
        leds <= data[7:0];
      end
    end
  end

`ifdef DMEM_RESP_TXFIFO_EN
  localparam int          PTR_W        = $clog2(TX_DEPTH);
  localparam logic [4:0]  TX_FULL      = 5'(TX_DEPTH);
  localparam logic [11:0] ADDR_TXDATA  = 12'hF02;

  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [4:0]       tx_count;
  logic             ovf;
  logic             tx_full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic             clr_ovf;

  assign tx_valid  = tx_count != 5'd0;
  assign tx_full   = tx_count == TX_FULL;
  assign pop       = tx_valid && tx_ready;
  assign push_req  = wren && (address_dmem == ADDR_TXDATA);
  // A pop on the same edge frees the slot the push needs
  assign push_ok   = push_req && (!tx_full || pop);
  assign clr_ovf   = wren && (address_dmem == ADDR_TXSTAT);
  assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : 8'd0;
  assign tx_status = {24'd0, tx_count, ovf, !tx_valid, tx_full};

  // FIFO byte storage, written at the tail on an accepted push
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tx_count <= 5'd0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        tx_count <= tx_count + 5'd1;
      end else if (pop && !push_ok) begin
        tx_count <= tx_count - 5'd1;
      end
      if (push_req && !push_ok) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign tx_valid        = 1'b0;
  assign tx_data         = 8'd0;
  assign tx_status       = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: the driver issues one port
// operation per clock and queues the expected q_dmem; a read monitor and a
// TX drain monitor pop and compare independently.
module tb_dmem_mmio_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_dmem = 12'hFFF;
  logic [31:0] data = 32'd0;
  logic        wren = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] q_dmem;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;

  dmem_mmio_responder #(.RAM_DEPTH(1024), .TX_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .leds(leds), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

`ifdef DMEM_RESP_TXFIFO_EN
  localparam logic [31:0] STAT_IDLE = 32'h0000_0002;
`else
  localparam logic [31:0] STAT_IDLE = 32'h0000_0000;
`endif

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        rd_q[$];
  logic [7:0]  tx_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_cyc;

  // Reference cycle count: edges seen since reset release
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic op(input logic [11:0] a, input logic w, input logic [31:0] d,
                    input bit chk, input logic [31:0] e, input string n);
    @(posedge clock);
    #2;
    address_dmem = a;
    wren         = w;
    data         = d;
    rd_q.push_back('{chk, e, n});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    op(a, 1'b1, d, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n);
    op(a, 1'b0, 32'd0, 1'b1, e, n);
  endtask

  task automatic idle();
    op(12'hFFF, 1'b0, 32'd0, 1'b1, 32'd0, "idle_rd");
  endtask

  task automatic rd_cycle(input string n);
    @(posedge clock);
    #2;
    address_dmem = 12'hF00;
    wren         = 1'b0;
    rd_q.push_back('{1'b1, tb_cyc, n});
  endtask

  // Read monitor: one queued expectation per clock edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset && rd_q.size() > 0) begin
        exp_t e;
        e = rd_q.pop_front();
        if (e.chk) check(e.name, q_dmem, e.exp);
      end
    end
  end

  // Drain monitor: a handshake seen mid-cycle completes on the next edge
  initial begin
    forever begin
      @(negedge clock);
      if (reset && tx_valid && tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else                  check("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_q_dmem", q_dmem, 32'd0);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // RAM write then read, then read-before-write on the same edge
    wr(12'h005, 32'hDEADBEEF);
    rd(12'h005, 32'hDEADBEEF, "ram_rd");
    op(12'h005, 1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF, "rbw_old");
    rd(12'h005, 32'h12345678, "rbw_new");

    // Top of RAM, hole above it, reserved MMIO, read-only CYCLE
    wr(12'h3FF, 32'h0BADCAFE);
    wr(12'h400, 32'hCAFEF00D);
    rd(12'h3FF, 32'h0BADCAFE, "ram_top");
    rd(12'h400, 32'd0, "hole_lo_rd");
    rd(12'hEFF, 32'd0, "hole_hi_rd");
    rd(12'hF04, 32'd0, "resv_rd");
    wr(12'hF00, 32'h0000_0055);

    // Cycle counter: consecutive reads, then wrap
    rd_cycle("cycle_a");
    rd_cycle("cycle_b");
    @(posedge clock);
    #2;
    address_dmem = 12'hF00;
    wren         = 1'b0;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    release dut.cycle_cnt;
    rd_q.push_back('{1'b1, 32'hFFFF_FFFF, "cycle_max"});
    rd(12'hF00, 32'd0, "cycle_wrap");

`ifdef DMEM_RESP_TXFIFO_EN
    // Overflow with the consumer stalled, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(12'hF02, {24'hABCDEF, 8'(8'h41 + i)});
      if (i < 4) tx_q.push_back(8'(8'h41 + i));
    end
    rd(12'hF03, 32'h0000_0025, "stat_full_ovf");
    tx_ready = 1'b1;
    repeat (5) idle();
    check("tx_valid_drained", {31'd0, tx_valid}, 32'd0);
    rd(12'hF03, 32'h0000_0006, "stat_empty_ovf");
    wr(12'hF03, 32'd0);
    rd(12'hF03, 32'h0000_0002, "stat_ovf_clr");

    // Push into a full FIFO on an edge that also pops
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(12'hF02, {24'd0, 8'(8'hA1 + i)});
      tx_q.push_back(8'(8'hA1 + i));
    end
    wr(12'hF02, 32'h0000_0099);
    tx_ready = 1'b1;
    tx_q.push_back(8'h99);
    rd(12'hF03, 32'h0000_0021, "stat_pushpop");
    repeat (5) idle();
    rd(12'hF03, 32'h0000_0002, "stat_drained");
    rd(12'hF02, 32'd0, "txd_rd");
`else
    // FIFO absent: its registers read zero and the drain port stays idle
    tx_ready = 1'b1;
    wr(12'hF02, 32'h0000_0077);
    rd(12'hF02, 32'd0, "txd_rd");
    rd(12'hF03, 32'd0, "txstat_rd");
    check("tx_valid_off", {31'd0, tx_valid}, 32'd0);
    check("tx_data_off", {24'd0, tx_data}, 32'd0);
`endif

    // LED register, then asynchronous reset mid-stream
    wr(12'hF01, 32'hFFFF_FFA5);
    rd(12'hF01, 32'h0000_00A5, "led_rd");
    check("leds_out", {24'd0, leds}, 32'h0000_00A5);
    tx_ready = 1'b0;
    wr(12'hF02, 32'h0000_005A);
    rd(12'h005, 32'h12345678, "ram_before_rst");
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("arst_q_dmem", q_dmem, 32'd0);
    check("arst_leds", {24'd0, leds}, 32'd0);
    check("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("arst_tx_data", {24'd0, tx_data}, 32'd0);
    tx_q.delete();
    @(negedge clock);
    reset = 1'b1;
    rd(12'h005, 32'h12345678, "ram_kept");
    rd(12'hF01, 32'd0, "led_after_rst");
    rd_cycle("cycle_after_rst");
    rd(12'hF03, STAT_IDLE, "stat_after_rst");
    idle();
    @(posedge clock);
    #3;
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
